// File: rtl/um_upscale2x_pkg.sv
// Shared constants and types for the 2x nearest-neighbour upscaler.
// Covers the DP word layout, the frame geometry and the pixel type.
package um_upscale2x_pkg;

  localparam int UM_SRC_W = 960;
  localparam int UM_DST_W = 1920;
  localparam int UM_DST_H = 1080;
  localparam int UM_DW    = 24;
  localparam int UM_AW    = 10;
  localparam int UM_CW    = 11;

  // Field offsets inside the 27-bit DP word {VS,HS,DE,R,G,B}
  localparam int DP_VS = 26;
  localparam int DP_HS = 25;
  localparam int DP_DE = 24;

  // Bit positions inside the 3-bit sync stream {VS,HS,DE}
  localparam int SYNC_VS = 2;
  localparam int SYNC_HS = 1;
  localparam int SYNC_DE = 0;

  typedef logic [UM_DW-1:0] rgb24_t;

  function automatic logic [UM_CW-1:0] sat_inc(input logic [UM_CW-1:0] v,
                                               input logic [UM_CW-1:0] lim);
    return (v >= lim) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/um_linebuf_pp.sv
// Ping-pong line buffer: two 1R1W banks with synchronous read, plus the
// per-bank full flags (sof clear, then read-side release, with set winning).
module um_linebuf_pp
  import um_upscale2x_pkg::*;
#(
  parameter int SRC_W = UM_SRC_W,
  parameter int DW    = UM_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [UM_AW-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  input  logic             rd_sel,
  input  logic [UM_AW-1:0] rd_addr,
  output logic [DW-1:0]    rd_data,
  input  logic             clr_all,
  input  logic             set_en,
  input  logic             set_sel,
  input  logic             rel_en,
  input  logic             rel_sel,
  output logic [1:0]       bank_full
);

  localparam int IW = (SRC_W > 1) ? $clog2(SRC_W) : 1;

  logic [DW-1:0] bank0 [SRC_W];
  logic [DW-1:0] bank1 [SRC_W];
  logic [1:0]    rel_mask;
  logic [1:0]    set_mask;
  logic [1:0]    full_next;

  // Bank write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) bank1[wr_addr[IW-1:0]] <= wr_data;
      else        bank0[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  // Synchronous read port, holds its data outside active video
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= rd_sel ? bank1[rd_addr[IW-1:0]] : bank0[rd_addr[IW-1:0]];
    end
  end

  // Full-flag update: clear-all, then release, then completion set on top
  always_comb begin
    rel_mask  = rel_en ? (2'b01 << rel_sel) : 2'b00;
    set_mask  = set_en ? (2'b01 << set_sel) : 2'b00;
    full_next = (clr_all ? 2'b00 : (bank_full & ~rel_mask)) | set_mask;
  end

  // Full-flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_full <= 2'b00;
    else        bank_full <= full_next;
  end

endmodule

// File: rtl/um_upscale2x.sv
// 2x nearest-neighbour upscaler: buffers source lines in a ping-pong buffer
// and replays each line twice, pixel-doubled, under the external sync stream.
module um_upscale2x
  import um_upscale2x_pkg::*;
#(
  parameter int SRC_W = UM_SRC_W,
  parameter int DST_W = UM_DST_W,
  parameter int DW    = UM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pix,
  input  logic          in_sof,
  input  logic          in_eol,
  input  logic [2:0]    sync_in,
  output logic [DW+2:0] dp_out,
  output logic          underflow,
  output logic          overflow
);

  localparam logic [UM_AW-1:0] LAST_X = UM_AW'(SRC_W - 1);
  localparam logic [UM_CW-1:0] LAST_H = UM_CW'(DST_W - 1);

  logic [UM_AW-1:0] wr_x;
  logic             wr_bank;
  logic             rd_bank;
  logic [UM_CW-1:0] h_o;
  logic [UM_CW-1:0] v_o;
  logic [2:0]       sync_d;
  logic             de_d;
  logic             line_ok;
  logic [1:0]       bank_full;
  logic [DW-1:0]    rd_data;

  logic             wr_en;
  logic             wr_sel;
  logic [UM_AW-1:0] wr_addr;
  logic             line_done;
  logic             drop;
  logic             de;
  logic             vs;
  logic             line_start;
  logic             line_end;
  logic             rel_en;
  logic             clr_all;

  assign de   = sync_in[SYNC_DE];
  assign vs   = sync_in[SYNC_VS];
  assign de_d = sync_d[SYNC_DE];

  // Write decode: sof restarts at bank 0 address 0, full bank drops the pixel
  always_comb begin
    wr_en     = 1'b0;
    wr_sel    = wr_bank;
    wr_addr   = wr_x;
    line_done = 1'b0;
    drop      = 1'b0;
    if (en && in_valid && in_sof) begin
      wr_en     = 1'b1;
      wr_sel    = 1'b0;
      wr_addr   = {UM_AW{1'b0}};
      line_done = in_eol || (LAST_X == {UM_AW{1'b0}});
    end else if (en && in_valid && !bank_full[wr_bank]) begin
      wr_en     = 1'b1;
      line_done = in_eol || (wr_x == LAST_X);
    end else if (en && in_valid) begin
      drop = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Read-side events derived from the sync stream
  always_comb begin
    line_start = en && de && !de_d;
    line_end   = en && !de && de_d;
    rel_en     = line_end && v_o[0] && !vs;
    clr_all    = !en || (in_valid && in_sof);
  end

  // Write counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_x    <= {UM_AW{1'b0}};
      wr_bank <= 1'b0;
    end else if (!en) begin
      wr_x    <= {UM_AW{1'b0}};
      wr_bank <= 1'b0;
    end else if (wr_en && line_done) begin
      wr_x    <= {UM_AW{1'b0}};
      wr_bank <= ~wr_sel;
    end else if (wr_en) begin
      wr_x    <= wr_addr + 10'd1;
      wr_bank <= wr_sel;
    end
  end

  // Read counters: the second replica line of a bank releases it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_o     <= {UM_CW{1'b0}};
      v_o     <= {UM_CW{1'b0}};
      rd_bank <= 1'b0;
    end else if (!en || vs) begin
      h_o     <= {UM_CW{1'b0}};
      v_o     <= {UM_CW{1'b0}};
      rd_bank <= 1'b0;
    end else if (line_end) begin
      h_o <= {UM_CW{1'b0}};
      v_o <= v_o + 11'd1;
      if (v_o[0]) rd_bank <= ~rd_bank;
    end else if (de) begin
      h_o <= sat_inc(h_o, LAST_H);
    end
  end

  // Sync delay, line validity and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d    <= 3'b000;
      line_ok   <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sync_d <= sync_in;
      if (!en)             line_ok <= 1'b0;
      else if (line_start) line_ok <= bank_full[rd_bank];
      if (line_start && !bank_full[rd_bank]) underflow <= 1'b1;
      if (drop)                              overflow  <= 1'b1;
    end
  end

  um_linebuf_pp #(
    .SRC_W (SRC_W),
    .DW    (DW)
  ) u_linebuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (in_pix),
    .rd_en     (en && de),
    .rd_sel    (rd_bank),
    .rd_addr   (h_o[UM_AW:1]),
    .rd_data   (rd_data),
    .clr_all   (clr_all),
    .set_en    (wr_en && line_done),
    .set_sel   (wr_sel),
    .rel_en    (rel_en),
    .rel_sel   (rd_bank),
    .bank_full (bank_full)
  );

  // RAM data lines up with the delayed sync; gate it outside valid lines
  assign dp_out = {sync_d, (de_d && line_ok) ? rd_data : {DW{1'b0}}};

endmodule

// File: doc/um_upscale2x.md
Name: um_upscale2x

Overview:
- Downstream neighbour of the IG 2x2-average stage.
- Consumes the decimated 960x540 RGB stream and produces a 1920x1080 DisplayPort-style word stream by 2x nearest-neighbour replication, horizontally and vertically.
- Output timing is slaved to the Sync_UM sync stream ({VS,HS,DE}).
- Input lines are buffered in an internal ping-pong line buffer (two banks of SRC_W x 24).

Parameters:
- SRC_W, 960, source pixels per line.
- DST_W, 1920, output active pixels per line (= 2*SRC_W).
- DW, 24, pixel width {R[7:0],G[7:0],B[7:0]}.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset.
- en  in  1  UM function enable.
- in_valid  in  1  source pixel strobe.
- in_pix  in  24  source pixel {R,G,B}.
- in_sof  in  1  start of frame; qualified by in_valid, marks first pixel.
- in_eol  in  1  end of line; qualified by in_valid, marks last pixel.
- sync_in  in  3  output timing {VS,HS,DE} (Sync_UM).
- dp_out  out  27  {VS,HS,DE,R,G,B}.
- underflow  out  1  sticky: output line started with no ready bank.
- overflow  out  1  sticky: source pixel arrived with no free bank.

Interface: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset: dp_out=0, underflow=0, overflow=0, both bank_full=0, wr_bank=0, rd_bank=0, wr_x=0, h_o=0, v_o=0, de_d=0.
- Write side, when en=1:
  - in_valid&in_sof forces wr_x=0, wr_bank=0 and clears both bank_full before writing the pixel at address 0.
  - in_valid with bank_full[wr_bank]=0: buf[wr_bank][wr_x]<=in_pix, then wr_x++.
  - Line complete when in_eol or wr_x==SRC_W-1. On completion: bank_full[wr_bank]<=1, wr_bank toggles, wr_x=0.
  - Short line (in_eol early): unwritten addresses keep stale data. No error is flagged.
  - in_valid with bank_full[wr_bank]=1: pixel dropped, overflow<=1, wr_x unchanged.
- Read side, when en=1:
  - Line start = rising edge of sync_in DE (DE=1 and de_d=0). At line start, line_ok<=bank_full[rd_bank]. If the bank is not full, underflow<=1 and the whole line outputs RGB=0.
  - While DE=1: read address = h_o>>1 from rd_bank, then h_o++. h_o saturates at DST_W-1.
  - At DE falling edge: h_o=0, v_o++. If v_o[0]=1 (second replica line done): bank_full[rd_bank]<=0, rd_bank toggles.
  - VS=1: h_o=0, v_o=0, rd_bank=0. bank_full is not touched.
- Latency: exactly 1 clk. dp_out[26:24] = sync_in delayed 1 cycle. dp_out[23:0] = buffer read data when delayed DE=1 and line_ok=1, else 0.
- Simultaneous events:
  - Write-completion set and read-side clear in the same cycle on different banks: both apply.
  - Same bank (only possible under misuse): set wins.
  - in_sof clears bank_full; this has priority over a read-side clear.
- en=0: write and read counters held at reset values, bank_full cleared, dp_out={sync_in delayed 1, 24'd0}. Sticky flags are held, not cleared.
- Reset mid-line: all state returns to reset values immediately. The first output line after reset flags underflow unless a source line completes first.
- Arithmetic: h_o is 11 bits, v_o is 11 bits; v_o wraps at 2048 and only bit 0 is used functionally. Buffer address is 10 bits.

Decomposition:
- Shared package: DP word field offsets (VS=26, HS=25, DE=24), SRC_W/DST_W/DST_H constants, RGB24 pixel typedef.
- One sub-module, um_linebuf_pp: two 1R1W banks of SRC_W x DW with synchronous read and bank_full bookkeeping. It maps onto two MEM2048X24 instances in the integrated design.
- Top holds the write/read counters, sync delay and flags.

Test Plan:
- Single line: write 960 pixels with R=x[7:0], G=0x55, B=0xAA, then two DE pulses of 1920 cycles. Each output line shows pixel n = {n>>1, 0x55, 0xAA}, first pixel exactly 1 clk after DE rises, and bank 0 is freed after the second line.
- Full frame: 540 source lines interleaved with 1080 DE lines, source line k delivered before output line 2k starts. Output line j equals source line j>>1. underflow=0 and overflow=0 throughout.
- Underflow: DE rises with no source line written. The 1920 output pixels are 0, underflow=1 and stays 1; sync bits still pass with 1-cycle delay.
- Overflow: write three source lines with no DE activity. The third line's pixels are dropped and overflow=1; after two output lines, a fourth line writes into bank 0 correctly.
- Early in_eol at pixel 499, then DE: output pixels 0..999 carry the new data and bank_full toggles. A mid-frame in_sof clears both banks and writes address 0 of bank 0.
- Async rst_n asserted mid-line: dp_out=0 within the same cycle, all flags clear, and normal operation resumes on the next in_sof.
